muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit for the RV32M extension, sitting beside the single-cycle ALU in EX.
- Accepts one operation through a start/busy/done handshake. Holds the pipeline via busy while it runs 32 radix-2 shift-add or shift-subtract steps over a shared accumulator.
- Returns a sign-corrected 32-bit result.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation. Sampled only in IDLE.
- Funct3  in  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  XLEN  rs1 value (multiplicand/dividend).
- SrcB  in  XLEN  rs2 value (multiplier/divisor).
- flush  in  1  abort the current operation (branch mispredict/exception).
- busy  out  1  high from accept edge until DONE is exited. Hazard unit stalls IF/ID/EX on it.
- done  out  1  one-cycle pulse; Result valid in that cycle.
- Result  out  XLEN  final value, held until next accept.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: state=IDLE, busy=0, done=0, Result=0, counter=0, all internal registers=0. Reset mid-operation abandons the operation with no done.
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE: on start=1 and flush=0, latch Funct3 and operands. Convert operands to magnitudes per op signedness and record result sign. Clear accumulator and counter. Go to CALC. busy=1 from this edge.
- CALC: one step per cycle. Counter increments 0..XLEN-1; leave for SIGN after the step with counter==XLEN-1.
  - MUL*: 2*XLEN-bit product register.
  - DIV*/REM*: restoring division with XLEN+1-bit partial remainder.
- SIGN: apply two's-complement negation where required and select the result:
  - MUL: low word. MULH/MULHSU/MULHU: high word.
  - DIV*: quotient. REM*: remainder, which takes the sign of the dividend.
  - Register into Result. Go to DONE.
- DONE: done=1, busy=1. Next edge goes to IDLE with busy=0. A start in DONE is ignored; the requester re-presents it in IDLE.
- Latency: accept edge t gives done high in the cycle after edge t+XLEN+1, i.e. 34 cycles. Not-yet-accepted start cycles do not count.
- Divide by zero: quotient = all ones (DIV and DIVU). Remainder = dividend.
- Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Special-result handling: a flag latched at accept forces the SIGN mux. Latency is unchanged unless the feature below is compiled in.
- start while busy: ignored; no queuing.
- flush: in any non-IDLE state, return to IDLE at the next edge. done stays 0 and Result keeps its previous value. flush with start in IDLE means no accept. flush in the DONE cycle does not retract done.
- Counter wrap: width clog2(XLEN). The counter never exceeds XLEN-1.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and multiply with either operand zero skip CALC and SIGN. IDLE goes straight to DONE, so done is high in the cycle after the accept edge (latency 1). All other ops keep the 34-cycle latency.
- Undefined: every op has the fixed 34-cycle latency.
- Results are identical in both builds.

Decomposition:
- muldiv_pkg: enum state_t {IDLE, CALC, SIGN, DONE}; localparams for the eight Funct3 codes; helper functions is_signed_a/is_signed_b(funct3).
- One sub-module, muldiv_step: combinational single-step shift-add / shift-subtract datapath. The sequencer owns registers, FSM and counter.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3) → Result 0xFFFFFFEB. busy high 34 cycles; done single pulse 34 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100/7 → 14, REMU → 2. DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
  - With MULDIV_EARLY_OUT_EN: done 1 cycle after accept.
  - Without it: 34 cycles.
- Control corner cases:
  - flush 10 cycles into DIVU → no done; busy=0 next cycle; a new start on the following cycle is accepted and completes correctly.
  - start held during busy → only one accept.
  - reset_n low mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and RV32M op encodings for the iterative multiply/divide unit.
// Optional build macro MULDIV_EARLY_OUT_EN is consumed by muldiv_sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_signed_a(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// acc holds {product} for multiply, or {remainder[XLEN:0], quotient[XLEN-1:0]} for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN:0]   acc_next
);

    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        addend  = acc[0] ? operand : '0;
        sum     = acc[2*XLEN:XLEN] + {1'b0, addend};
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            // A negative trial difference restores the shifted remainder and shifts in a 0.
            acc_next = diff[XLEN] ? {shifted, acc[XLEN-2:0], 1'b0}
                                  : {diff,    acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {1'b0, sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer with start/busy/done handshake.
// Define MULDIV_EARLY_OUT_EN to finish special-case operations in one cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_t          state, next_state;
    logic [2:0]      op;
    logic [2*XLEN:0] acc;
    logic [2*XLEN:0] acc_step;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] special_val;
    logic            special;
    logic            neg_res;
    logic [CNT_W-1:0] cnt;

    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, mul_zero, special_in, neg_in;
    logic [XLEN-1:0] special_in_val;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0] quo, rem, sign_result;

    assign accept = (state == IDLE) && start && !flush;

    // Operand conditioning at accept: magnitudes, result sign and special-case detection.
    always_comb begin
        a_neg    = is_signed_a(Funct3) & SrcA[XLEN-1];
        b_neg    = is_signed_b(Funct3) & SrcB[XLEN-1];
        mag_a    = a_neg ? -SrcA : SrcA;
        mag_b    = b_neg ? -SrcB : SrcB;
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                   (SrcA == MOST_NEG) && (&SrcB);
        mul_zero = !Funct3[2] && ((SrcA == '0) || (SrcB == '0));
        special_in = div_zero || div_ovf || mul_zero;
        // Remainder follows the dividend's sign; quotient and products follow the XOR.
        neg_in = (Funct3[2] && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
        special_in_val = '0;
        if (div_zero) begin
            special_in_val = Funct3[1] ? SrcA : '1;
        end else if (div_ovf) begin
            special_in_val = Funct3[1] ? '0 : MOST_NEG;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (op[2]),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_step)
    );

    always_comb begin
        prod_signed = neg_res ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
        quo         = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem         = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (special) begin
            sign_result = special_val;
        end else begin
            case (op)
                F3_MUL:                     sign_result = prod_signed[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: sign_result = prod_signed[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:            sign_result = quo;
                default:                    sign_result = rem;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (EARLY_OUT && special_in) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    next_state = IDLE;
                end else if (cnt == LAST) begin
                    next_state = SIGN;
                end
            end
            SIGN: begin
                busy       = 1'b1;
                next_state = flush ? IDLE : DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op          <= '0;
            acc         <= '0;
            operand     <= '0;
            special     <= 1'b0;
            special_val <= '0;
            neg_res     <= 1'b0;
            cnt         <= '0;
            Result      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op          <= Funct3;
                        acc         <= {{(XLEN+1){1'b0}}, (Funct3[2] ? mag_a : mag_b)};
                        operand     <= Funct3[2] ? mag_b : mag_a;
                        special     <= special_in;
                        special_val <= special_in_val;
                        neg_res     <= neg_in;
                        cnt         <= '0;
                        if (EARLY_OUT && special_in) begin
                            Result <= special_in_val;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc <= acc_step;
                        cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                    end
                end
                SIGN: begin
                    if (!flush) begin
                        Result <= sign_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_result = '0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .Funct3  (Funct3),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .Result  (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1'b1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        if (!f[2] && (a == 0 || b == 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present one op, measure accept-to-done latency and busy coverage, then check the result.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        int lat;
        int busy_low;
        int exp_lat;
        logic [31:0] exp;
        exp     = ref_model(f, a, b);
        exp_lat = (EARLY && is_special(f, a, b)) ? 1 : 34;
        @(negedge clk);
        start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        lat = 1;
        busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_low++;
        start = 1'b0;
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy"}, 32'(busy_low), 32'd0);
        check({tag, " result"}, Result, exp);
        @(posedge clk); #1;
        check({tag, " idle"}, {30'b0, busy, done}, 32'd0);
        last_result = exp;
    endtask

    initial begin
        int seen;
        #12;
        check("reset outputs", {busy, done, Result[29:0]}, 32'd0);
        check("reset result", Result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mul value", last_result, 32'hFFFF_FFEB);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", 3'b101, 32'd100, 32'd7, 1'b0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 1'b0);
        run_op("div neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div by 0", 3'b100, 32'd5, 32'd0, 1'b0);
        run_op("rem by 0", 3'b110, 32'd5, 32'd0, 1'b0);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mul zero", 3'b001, 32'h0, 32'h1234_5678, 1'b0);

        // Flush ten cycles into a divide: no done, idle next cycle, Result unchanged.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush no done", 32'(seen), 32'd0);
        check("flush idle", {30'b0, busy, done}, 32'd0);
        check("flush result held", Result, last_result);
        run_op("after flush", 3'b101, 32'd1000, 32'd7, 1'b0);

        // Start held through the whole operation must accept exactly once.
        run_op("held start", 3'b110, 32'hFFFF_FF9C, 32'd7, 1'b1);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (busy) seen++;
        end
        check("held single accept", 32'(seen), 32'd0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d f%0d", i, f), f, a, b, 1'b0);
        end

        // Reset in the middle of CALC clears everything at once.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b000; SrcA = 32'd123; SrcB = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset mid busy", {31'b0, busy}, 32'd0);
        check("reset mid done", {31'b0, done}, 32'd0);
        check("reset mid result", Result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after reset", 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
